// File: rtl/rx_pkg.sv
// Shared types and default widths for the rx serial receive stage.
// Optional build macro used across the slice: RX_ERR_EN (adds sticky rx_err).
package rx_pkg;

    localparam int RX_DATA_WIDTH = 8;
    localparam int RX_ADDR_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rx_if.sv
// Sender/reader-facing signal bundle of the rx stage.
// RX_ERR_EN defined: the bundle also carries the sticky rx_err flag.
interface rx_if
    import rx_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH,
    parameter int ADDR_WIDTH = RX_ADDR_WIDTH
);

    logic                  tx_data;
    logic                  tx_valid;
    logic                  tx_finish;
    logic                  rx_ready;
    logic                  rx_done;
    logic [ADDR_WIDTH:0]   rx_count;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
`ifdef RX_ERR_EN
    logic                  rx_err;
`endif

    modport master (
        output tx_data, tx_valid, tx_finish, rd_en, rd_addr,
        input  rx_ready, rx_done, rx_count, rd_data
`ifdef RX_ERR_EN
        , input rx_err
`endif
    );

    modport slave (
        input  tx_data, tx_valid, tx_finish, rd_en, rd_addr,
        output rx_ready, rx_done, rx_count, rd_data
`ifdef RX_ERR_EN
        , output rx_err
`endif
    );

endinterface

// File: rtl/rx_ram.sv
// Word store for rx: one synchronous write port, one synchronous read port.
// A read and write to the same address in one cycle returns the old word.
module rx_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Storage array: written on store, never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value while rd_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx.sv
// rx: deserialises LSB-first tx_data into words, stores them in rx_ram,
// paces the sender with rx_ready and latches rx_done on tx_finish.
// RX_ERR_EN defined: sticky rx_err for partial word, overflow, short transfer.
module rx
    import rx_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH,
    parameter int ADDR_WIDTH = RX_ADDR_WIDTH
) (
    input logic clk,
    input logic rst_n,
    rx_if.slave bus
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]       LAST_BIT  = CW'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH:0] COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    rx_state_t             state, next_state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  shift_en;
    logic                  store_en;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and datapath strobes; tx_finish outranks tx_valid.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        store_en   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.tx_finish) begin
                    next_state = DONE;
                end else if (bus.tx_valid) begin
                    shift_en   = 1'b1;
                    next_state = RECV;
                end
            end
            RECV: begin
                if (bus.tx_finish) begin
                    next_state = DONE;
                end else if (bus.tx_valid) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        next_state = STORE;
                    end
                end
            end
            STORE: begin
                store_en   = 1'b1;
                next_state = bus.tx_finish ? DONE : IDLE;
            end
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Shift register, bit counter, write pointer, word count and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shr          <= '0;
            bit_cnt      <= '0;
            wr_addr      <= '0;
            bus.rx_count <= '0;
            bus.rx_ready <= 1'b0;
            bus.rx_done  <= 1'b0;
        end else begin
            if (shift_en) begin
                shr <= {bus.tx_data, shr[DATA_WIDTH-1:1]};
                if (state == IDLE) begin
                    bit_cnt <= CW'(1);
                end else if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (store_en) begin
                wr_addr <= wr_addr + 1'b1;
                if (bus.rx_count != COUNT_MAX) begin
                    bus.rx_count <= bus.rx_count + 1'b1;
                end
            end
            bus.rx_ready <= (next_state == IDLE);
            bus.rx_done  <= (next_state == DONE);
        end
    end

`ifdef RX_ERR_EN
    logic err_set;

    // Error conditions; DONE ignores further sender activity.
    always_comb begin
        err_set = 1'b0;
        if (state != DONE && bus.tx_finish &&
            (state == RECV || bus.rx_count != COUNT_MAX)) begin
            err_set = 1'b1;
        end
        if (store_en && bus.rx_count == COUNT_MAX) begin
            err_set = 1'b1;
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rx_err <= 1'b0;
        end else if (err_set) begin
            bus.rx_err <= 1'b1;
        end
    end
`endif

    rx_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (store_en),
        .wr_addr(wr_addr),
        .wr_data(shr),
        .rd_en  (bus.rd_en),
        .rd_addr(bus.rd_addr),
        .rd_data(bus.rd_data)
    );

endmodule

// File: tb/tb_rx.sv
// Scoreboard bench for rx: readback expectations are queued at request time
// and checked by an independent monitor when rd_data becomes valid.
// Build with RX_ERR_EN defined to include rx_err checks.
module tb_rx;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic rd_pend;
    logic [7:0] exp_q [$];

    rx_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

    rx #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A readback is in flight if rd_en was sampled by a clock edge out of reset.
    always @(posedge clk) rd_pend <= rst_n && bus.rd_en;

    // Monitor: pop and compare one expected word per completed readback.
    always @(negedge clk) begin
        if (rd_pend === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: actual=%0h required=<none>", bus.rd_data);
            end else begin
                chk("rd_data", bus.rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic read(input logic [1:0] addr, input logic [7:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 50 && bus.rx_ready !== 1'b1; k++) @(negedge clk);
        if (bus.rx_ready !== 1'b1) chk("ready_timeout", bus.rx_ready, 1);
    endtask

    task automatic drive_bit(input logic b);
        bus.tx_valid = 1'b1;
        bus.tx_data  = b;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // Send one word LSB first; optional stall after bit stall_at and
    // optional readback issued during the STORE cycle.
    task automatic send_word(input logic [7:0] w, input int stall_at, input int stall_len,
                             input int coll_addr, input logic [7:0] coll_exp);
        wait_ready();
        for (int i = 0; i < 8; i++) begin
            drive_bit(w[i]);
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    chk("stall_ready", bus.rx_ready, 0);
                    @(negedge clk);
                end
            end
        end
        if (coll_addr >= 0) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = coll_addr[1:0];
            exp_q.push_back(coll_exp);
        end
        chk("store_ready", bus.rx_ready, 0);
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk("ready_back", bus.rx_ready, 1);
    endtask

    task automatic send(input logic [7:0] w);
        send_word(w, -1, 0, -1, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_finish = 1'b0;
        bus.rd_en     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_finish();
        bus.tx_finish = 1'b1;
        @(negedge clk);
        bus.tx_finish = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.tx_data   = 1'b0;
        bus.tx_valid  = 1'b0;
        bus.tx_finish = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;

        // 1 Reset
        repeat (2) @(negedge clk);
        chk("rst_ready", bus.rx_ready, 0);
        chk("rst_done", bus.rx_done, 0);
        chk("rst_count", bus.rx_count, 0);
        chk("rst_rd_data", bus.rd_data, 0);
`ifdef RX_ERR_EN
        chk("rst_err", bus.rx_err, 0);
`endif
        rst_n = 1'b1;
        chk("ready_at_release", bus.rx_ready, 0);
        @(negedge clk);
        chk("ready_after_release", bus.rx_ready, 1);

        // 2 Normal transfer of four words
        send(8'hA5);
        chk("count_1", bus.rx_count, 1);
        send(8'h3C);
        send(8'hFF);
        send(8'h01);
        chk("count_4", bus.rx_count, 4);
        pulse_finish();
        chk("normal_done", bus.rx_done, 1);
        chk("normal_ready_low", bus.rx_ready, 0);
        chk("normal_count", bus.rx_count, 4);
`ifdef RX_ERR_EN
        chk("normal_err", bus.rx_err, 0);
`endif
        read(2'd0, 8'hA5);
        read(2'd1, 8'h3C);
        read(2'd2, 8'hFF);
        read(2'd3, 8'h01);
        @(negedge clk);
        chk("rd_hold", bus.rd_data, 8'h01);
        // DONE ignores further bits
        for (int i = 0; i < 8; i++) drive_bit(1'b1);
        @(negedge clk);
        chk("done_count_hold", bus.rx_count, 4);
        chk("done_sticky", bus.rx_done, 1);
        chk("done_ready_low", bus.rx_ready, 0);
        read(2'd0, 8'hA5);

        // 3 Stall mid-word
        do_reset();
        send_word(8'h5A, 3, 3, -1, 8'h00);
        chk("stall_count", bus.rx_count, 1);
        read(2'd0, 8'h5A);

        // 4 Abort a partial word
        wait_ready();
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        pulse_finish();
        chk("abort_done", bus.rx_done, 1);
        chk("abort_count", bus.rx_count, 1);
        chk("abort_ready", bus.rx_ready, 0);
`ifdef RX_ERR_EN
        chk("abort_err", bus.rx_err, 1);
`endif
        read(2'd1, 8'h3C);
        read(2'd0, 8'h5A);

        // 4b tx_finish together with the first tx_valid
        do_reset();
        bus.tx_valid  = 1'b1;
        bus.tx_data   = 1'b1;
        bus.tx_finish = 1'b1;
        @(negedge clk);
        bus.tx_valid  = 1'b0;
        bus.tx_finish = 1'b0;
        chk("first_finish_done", bus.rx_done, 1);
        chk("first_finish_count", bus.rx_count, 0);
`ifdef RX_ERR_EN
        chk("short_err", bus.rx_err, 1);
`endif

        // 5 Overflow: fifth word overwrites address 0 (collision read sees old)
        do_reset();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
`ifdef RX_ERR_EN
        chk("pre_ovf_err", bus.rx_err, 0);
`endif
        send_word(8'h55, -1, 0, 0, 8'h11);
        chk("ovf_count", bus.rx_count, 4);
`ifdef RX_ERR_EN
        chk("ovf_err", bus.rx_err, 1);
`endif
        read(2'd0, 8'h55);
        read(2'd1, 8'h22);
        read(2'd3, 8'h44);

        // 6 Reset in the middle of a word
        do_reset();
        send(8'h77);
        read(2'd0, 8'h77);
        wait_ready();
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", bus.rx_ready, 0);
        chk("midrst_count", bus.rx_count, 0);
        chk("midrst_rd_data", bus.rd_data, 0);
        chk("midrst_done", bus.rx_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'hC3);
        chk("resend_count", bus.rx_count, 1);
        read(2'd0, 8'hC3);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
